// File: rtl/costas_loop_ctrl.sv
// costas_loop_ctrl: steps the Costas loop filter through acquire, track and lock,
// judging each filter update by the phase-error magnitude.
module costas_loop_ctrl #(
   parameter int               ERR_W       = 26,
   parameter logic [ERR_W-1:0] LOCK_THR    = ERR_W'('h20000),
   parameter int               LOCK_CNT    = 32,
   parameter int               UNLOCK_CNT  = 8,
   parameter int               ACQ_TIMEOUT = 1024
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [ERR_W-1:0] err_in,
   input  logic             filt_valid,
   output logic             ce_out,
   output logic             filt_rst,
   output logic [1:0]       gain_sel,
   output logic             locked,
   output logic             lock_lost,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, TRK = 2'b10, LCK = 2'b11} state_t;
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);
   localparam int UW = $clog2(ACQ_TIMEOUT + 1);
   localparam logic [GW-1:0] G_FULL = GW'(LOCK_CNT);
   localparam logic [GW-1:0] G_HALF = GW'(LOCK_CNT / 2);
   localparam logic [BW-1:0] B_FULL = BW'(UNLOCK_CNT);
   localparam logic [UW-1:0] U_FULL = UW'(ACQ_TIMEOUT);
   state_t state_q, state_d;
   logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
   logic [BW-1:0] bad_cnt_q, bad_cnt_d, bad_inc;
   logic [UW-1:0] upd_cnt_q, upd_cnt_d, upd_inc;
   logic ce_q, ce_d, frst_q, frst_d, lost_q, lost_d;
   logic [ERR_W-1:0] neg_err, mag;
   logic good, far, upd, rs;
   // negating the most negative error wraps to itself, so it saturates to the largest positive
   assign neg_err  = -err_in;
   assign mag      = !err_in[ERR_W-1] ? err_in :
                     neg_err[ERR_W-1] ? {1'b0, {(ERR_W-1){1'b1}}} : neg_err;
   assign good     = mag < LOCK_THR;
   assign far      = {1'b0, mag} >= {LOCK_THR, 1'b0};
   assign upd      = filt_valid && state_q != IDLE && !frst_q;
   assign good_inc = good_cnt_q == G_FULL ? good_cnt_q : good_cnt_q + GW'(1);
   assign bad_inc  = bad_cnt_q == B_FULL ? bad_cnt_q : bad_cnt_q + BW'(1);
   assign upd_inc  = upd_cnt_q == U_FULL ? upd_cnt_q : upd_cnt_q + UW'(1);
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      upd_cnt_d  = upd_cnt_q;
      frst_d     = 1'b0;
      lost_d     = 1'b0;
      rs         = 1'b0;
      if (!enable) begin
         state_d    = IDLE;
         good_cnt_d = '0;
         bad_cnt_d  = '0;
         upd_cnt_d  = '0;
      end else if (state_q == IDLE) begin
         rs = 1'b1;
      end else if (upd) begin
         good_cnt_d = good ? good_inc : '0;
         bad_cnt_d  = good ? '0 : bad_inc;
         upd_cnt_d  = upd_inc;
         if (state_q == LCK && bad_cnt_d == B_FULL) begin
            rs     = 1'b1;
            lost_d = 1'b1;
         end else if (state_q == TRK && far) begin
            rs = 1'b1;
         end else if (state_q == TRK && good_cnt_d == G_FULL) begin
            state_d = LCK;
         end else if (state_q == ACQ && good_cnt_d == G_HALF) begin
            state_d = TRK;
         end else if (state_q == ACQ && upd_cnt_d == U_FULL) begin
            rs = 1'b1;
         end
      end
      if (rs) begin
         state_d    = ACQ;
         frst_d     = 1'b1;
         good_cnt_d = '0;
         bad_cnt_d  = '0;
         upd_cnt_d  = '0;
      end
      ce_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         upd_cnt_q  <= '0;
         ce_q       <= 1'b0;
         frst_q     <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         upd_cnt_q  <= upd_cnt_d;
         ce_q       <= ce_d;
         frst_q     <= frst_d;
         lost_q     <= lost_d;
      end
   end
   assign state     = state_q;
   assign ce_out    = ce_q;
   assign filt_rst  = frst_q;
   assign lock_lost = lost_q;
   assign locked    = state_q == LCK;
   assign gain_sel  = state_q == TRK ? 2'b01 : state_q == LCK ? 2'b00 : 2'b10;
endmodule

// File: tb/tb_costas_loop_ctrl.sv
// tb_costas_loop_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_costas_loop_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [25:0] err_in = '0;
   logic        filt_valid = 1'b0;
   logic        ce_out, filt_rst, locked, lock_lost;
   logic [1:0]  gain_sel, state;
   int n_assert = 0;
   int n_fail = 0;
   int m_state = 0, m_good = 0, m_bad = 0, m_upd = 0;
   logic m_frst = 1'b0, m_lost = 1'b0;
   localparam logic [25:0] GOOD = 26'h0000100;
   localparam logic [25:0] BAD  = 26'h0100000;
   costas_loop_ctrl dut (
      .clk(clk), .rst(rst), .enable(enable), .err_in(err_in), .filt_valid(filt_valid),
      .ce_out(ce_out), .filt_rst(filt_rst), .gain_sel(gain_sel), .locked(locked),
      .lock_lost(lock_lost), .state(state)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic r, input logic en, input logic v, input logic [25:0] e);
      int ei, mag;
      logic u;
      if (r) begin
         m_state = 0; m_good = 0; m_bad = 0; m_upd = 0; m_frst = 0; m_lost = 0;
         return;
      end
      u = v && m_state != 0 && !m_frst;
      m_frst = 0;
      m_lost = 0;
      if (!en) begin
         m_state = 0; m_good = 0; m_bad = 0; m_upd = 0;
      end else if (m_state == 0) begin
         m_state = 1; m_frst = 1; m_good = 0; m_bad = 0; m_upd = 0;
      end else if (u) begin
         ei = int'($signed(e));
         mag = ei < 0 ? -ei : ei;
         if (mag > 33554431) mag = 33554431;
         m_upd = m_upd < 1024 ? m_upd + 1 : 1024;
         if (mag < 'h20000) begin
            m_good = m_good < 32 ? m_good + 1 : 32;
            m_bad = 0;
         end else begin
            m_good = 0;
            m_bad = m_bad < 8 ? m_bad + 1 : 8;
         end
         if ((m_state == 3 && m_bad == 8) || (m_state == 2 && mag >= 'h40000) ||
             (m_state == 1 && m_good != 16 && m_upd == 1024)) begin
            m_lost = m_state == 3;
            m_state = 1; m_frst = 1; m_good = 0; m_bad = 0; m_upd = 0;
         end else if (m_state == 2 && m_good == 32) m_state = 3;
         else if (m_state == 1 && m_good == 16) m_state = 2;
      end
   endtask
   task automatic step(input logic r, input logic en, input logic v, input logic [25:0] e);
      logic [1:0] g;
      rst = r; enable = en; filt_valid = v; err_in = e;
      @(posedge clk);
      model(r, en, v, e);
      #1;
      g = m_state == 3 ? 2'b00 : m_state == 2 ? 2'b01 : 2'b10;
      chk("outputs", {state, ce_out, filt_rst, gain_sel, locked, lock_lost},
          {2'(m_state), m_state != 0, m_frst, g, m_state == 3, m_lost});
   endtask
   task automatic pulse(input logic [25:0] e, input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 1, 1, e);
         step(0, 1, 0, '0);
      end
   endtask
   function automatic logic [25:0] pick(input int pg);
      int x;
      if ($urandom_range(0, 99) < pg) begin
         x = $urandom_range(0, 'h1FFFF);
         return $urandom_range(0, 1) ? 26'(-x) : 26'(x);
      end
      case ($urandom_range(0, 5))
         0: return 26'h0020000;
         1: return 26'h3FE0000;
         2: return 26'h003FFFF;
         3: return 26'h0040000;
         4: return 26'h2000000;
         default: return 26'($urandom);
      endcase
   endfunction
   initial begin
      int pg;
      // reset and start-up
      repeat (3) step(1, 0, 0, '0);
      chk("rst_state", 8'(state), 8'h0);
      chk("rst_gain", 8'(gain_sel), 8'h2);
      chk("rst_ce", 8'(ce_out), 8'h0);
      step(0, 0, 0, '0);
      chk("idle_hold", 8'(state), 8'h0);
      step(0, 1, 0, '0);
      chk("start_frst", {6'b0, filt_rst, ce_out}, 8'h3);
      chk("start_state", 8'(state), 8'h1);
      step(0, 1, 0, '0);
      chk("frst_one_clk", 8'(filt_rst), 8'h0);
      // acquire -> track -> lock
      pulse(GOOD, 15);
      chk("acq_15", 8'(state), 8'h1);
      pulse(GOOD, 1);
      chk("track_16", {4'b0, state, gain_sel}, 8'h9);
      pulse(GOOD, 15);
      chk("track_31", 8'(state), 8'h2);
      pulse(GOOD, 1);
      chk("lock_32", {4'b0, state, gain_sel}, 8'hC);
      chk("locked", 8'(locked), 8'h1);
      // lock hold and loss
      pulse(BAD, 7);
      pulse(GOOD, 1);
      chk("lock_hold", 8'(state), 8'h3);
      pulse(BAD, 7);
      step(0, 1, 1, BAD);
      chk("lock_lost", {4'b0, state, lock_lost, filt_rst}, 8'h7);
      step(0, 1, 0, '0);
      chk("lost_pulse_end", 8'(lock_lost), 8'h0);
      // acquisition timeout with the most negative error
      pulse(26'h2000000, 1023);
      chk("acq_1023", {6'b0, state}, 8'h1);
      step(0, 1, 1, 26'h2000000);
      chk("timeout_frst", {5'b0, state, filt_rst}, 8'h3);
      step(0, 1, 0, '0);
      pulse(GOOD, 15);
      chk("cleared_15", 8'(state), 8'h1);
      pulse(GOOD, 1);
      chk("cleared_16", 8'(state), 8'h2);
      // far-error boundary in track
      pulse(26'h003FFFF, 1);
      chk("near_far", {6'b0, state}, 8'h2);
      pulse(GOOD, 31);
      chk("good_reset", 8'(state), 8'h2);
      step(0, 1, 1, 26'h0040000);
      chk("far_exit", {5'b0, state, filt_rst}, 8'h3);
      step(0, 1, 0, '0);
      // disable wins over lock loss
      pulse(GOOD, 32);
      chk("relock", 8'(state), 8'h3);
      pulse(BAD, 7);
      step(0, 0, 1, BAD);
      chk("dis_state", 8'(state), 8'h0);
      chk("dis_pulses", {5'b0, lock_lost, filt_rst, ce_out}, 8'h0);
      step(0, 0, 0, '0);
      chk("dis_hold", 8'(state), 8'h0);
      // random traffic against the model
      pg = 97;
      for (int i = 0; i < 8000; i++) begin
         if (i % 400 == 0) pg = $urandom_range(0, 1) ? 97 : 45;
         step($urandom_range(0, 999) == 0, $urandom_range(0, 299) != 0,
              $urandom_range(0, 2) == 0, pick(pg));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
